// File: rtl/bandai2003_host.sv
// Console-side host for the BANDAI2003 cartridge mapper: sends the 5Ah/A5h unlock,
// receives and checks the 18-bit authentication frame, then runs bank-register cycles.
//
// state   | meaning
// IDLE    | waiting for START
// ACK     | ADDR=5Ah, first unlock byte
// NAK     | ADDR=A5h, second unlock byte
// HUNT    | waiting for the start bit on SO, bounded by BIT_TIMEOUT
// SHIFT   | 16 payload bits, LSB first
// STOP    | stop bit and payload compare
// FAILED  | unlock rejected; START retries
// READY   | unlocked, accepting bank requests
// SETUP   | address/CEn/DQ set up before the strobe
// STROBE  | OEn or WEn low for ACCESS_CYCLES
// HOLD    | strobe released, bus held one cycle
module bandai2003_host #(
    parameter logic [15:0] EXPECT        = 16'h28A0,
    parameter int          BIT_TIMEOUT   = 64,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SO,
    output logic [7:0]  ADDR,
    output logic        CEn,
    output logic        OEn,
    output logic        WEn,
    output logic [7:0]  DQ_OUT,
    output logic        DQ_OE,
    input  logic [7:0]  DQ_IN,
    input  logic        REQ,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_IDX,
    input  logic [7:0]  REQ_WDATA,
    output logic        ACK,
    output logic [7:0]  RDATA,
    output logic        UNLOCKED,
    output logic        FAIL,
    output logic        BUSY,
    output logic [15:0] WORD
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACK, S_NAK, S_HUNT, S_SHIFT, S_STOP,
        S_FAILED, S_READY, S_SETUP, S_STROBE, S_HOLD
    } state_t;

    localparam logic [7:0] HUNT_LOAD   = 8'(BIT_TIMEOUT);
    localparam logic [7:0] STROBE_LOAD = 8'(ACCESS_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       acc_we;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            acc_we   <= 1'b0;
            ADDR     <= 8'h00;
            CEn      <= 1'b1;
            OEn      <= 1'b1;
            WEn      <= 1'b1;
            DQ_OUT   <= 8'h00;
            DQ_OE    <= 1'b0;
            ACK      <= 1'b0;
            RDATA    <= 8'h00;
            UNLOCKED <= 1'b0;
            FAIL     <= 1'b0;
            BUSY     <= 1'b0;
            WORD     <= 16'h0000;
        end else begin
            ACK <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_ACK;
                        ADDR  <= 8'h5A;
                        WORD  <= 16'h0000;
                        BUSY  <= 1'b1;
                    end
                end
                S_ACK: begin
                    state <= S_NAK;
                    ADDR  <= 8'hA5;
                end
                S_NAK: begin
                    state <= S_HUNT;
                    ADDR  <= 8'h00;
                    cnt   <= HUNT_LOAD;
                end
                S_HUNT: begin
                    if (!SO) begin
                        state <= S_SHIFT;
                        cnt   <= 8'd15;
                    end else if (cnt == 8'd0) begin
                        state <= S_FAILED;
                        FAIL  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SHIFT: begin
                    WORD <= {SO, WORD[15:1]};
                    if (cnt == 8'd0) state <= S_STOP;
                    else             cnt   <= cnt - 8'd1;
                end
                S_STOP: begin
                    BUSY <= 1'b0;
                    if (!SO && WORD == EXPECT) begin
                        state    <= S_READY;
                        UNLOCKED <= 1'b1;
                    end else begin
                        state <= S_FAILED;
                        FAIL  <= 1'b1;
                    end
                end
                S_FAILED: begin
                    if (START) begin
                        state <= S_ACK;
                        FAIL  <= 1'b0;
                        ADDR  <= 8'h5A;
                        WORD  <= 16'h0000;
                        BUSY  <= 1'b1;
                    end
                end
                S_READY: begin
                    // a request landing on the ACK cycle is dropped, not queued
                    if (REQ && !ACK) begin
                        state  <= S_SETUP;
                        acc_we <= REQ_WE;
                        ADDR   <= {6'b110000, REQ_IDX};
                        CEn    <= 1'b0;
                        DQ_OE  <= REQ_WE;
                        if (REQ_WE) DQ_OUT <= REQ_WDATA;
                        BUSY   <= 1'b1;
                    end
                end
                S_SETUP: begin
                    state <= S_STROBE;
                    cnt   <= STROBE_LOAD;
                    if (acc_we) WEn <= 1'b0;
                    else        OEn <= 1'b0;
                end
                S_STROBE: begin
                    if (cnt == 8'd0) begin
                        state <= S_HOLD;
                        OEn   <= 1'b1;
                        WEn   <= 1'b1;
                        if (!acc_we) RDATA <= DQ_IN;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    state <= S_READY;
                    ACK   <= 1'b1;
                    CEn   <= 1'b1;
                    DQ_OE <= 1'b0;
                    ADDR  <= 8'h00;
                    BUSY  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bandai2003_host.sv
// Directed bench for bandai2003_host: drives the cartridge side (SO frame, DQ read
// data) from hand-written vectors and checks every output cycle by cycle.
`timescale 1ns/1ps
module tb_bandai2003_host;

    localparam int BIT_TO = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        SO = 1'b1;
    logic [7:0]  ADDR;
    logic        CEn, OEn, WEn;
    logic [7:0]  DQ_OUT;
    logic        DQ_OE;
    logic [7:0]  DQ_IN = 8'h00;
    logic        REQ = 1'b0;
    logic        REQ_WE = 1'b0;
    logic [1:0]  REQ_IDX = 2'd0;
    logic [7:0]  REQ_WDATA = 8'h00;
    logic        ACK;
    logic [7:0]  RDATA;
    logic        UNLOCKED, FAIL, BUSY;
    logic [15:0] WORD;

    int checks = 0;
    int failures = 0;
    logic [7:0] cart_reg [4];

    bandai2003_host #(.EXPECT(16'h28A0), .BIT_TIMEOUT(BIT_TO), .ACCESS_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SO(SO),
        .ADDR(ADDR), .CEn(CEn), .OEn(OEn), .WEn(WEn),
        .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .DQ_IN(DQ_IN),
        .REQ(REQ), .REQ_WE(REQ_WE), .REQ_IDX(REQ_IDX), .REQ_WDATA(REQ_WDATA),
        .ACK(ACK), .RDATA(RDATA), .UNLOCKED(UNLOCKED), .FAIL(FAIL),
        .BUSY(BUSY), .WORD(WORD)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},     32'(ADDR),     32'h00);
        check({tag, "_cen"},      32'(CEn),      32'd1);
        check({tag, "_oen"},      32'(OEn),      32'd1);
        check({tag, "_wen"},      32'(WEn),      32'd1);
        check({tag, "_dq_oe"},    32'(DQ_OE),    32'd0);
        check({tag, "_dq_out"},   32'(DQ_OUT),   32'h00);
        check({tag, "_ack"},      32'(ACK),      32'd0);
        check({tag, "_rdata"},    32'(RDATA),    32'h00);
        check({tag, "_unlocked"}, 32'(UNLOCKED), 32'd0);
        check({tag, "_fail"},     32'(FAIL),     32'd0);
        check({tag, "_busy"},     32'(BUSY),     32'd0);
        check({tag, "_word"},     32'(WORD),     32'h0000);
    endtask

    // one reset edge; the cartridge model is reset alongside
    task automatic apply_rst(input string tag);
        @(negedge CLK);
        RST = 1'b1; START = 1'b0; REQ = 1'b0; SO = 1'b1; DQ_IN = 8'h00;
        @(negedge CLK);
        check_reset_outputs(tag);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) cart_reg[i] = 8'h00;
    endtask

    task automatic do_unlock(input logic [15:0] pay, input logic stop_b, input logic exp_ok);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        check("unl_addr_5a", 32'(ADDR), 32'h5A);
        check("unl_busy_start", 32'(BUSY), 32'd1);
        check("unl_fail_clr", 32'(FAIL), 32'd0);
        @(negedge CLK);
        check("unl_addr_a5", 32'(ADDR), 32'hA5);
        @(negedge CLK);
        check("unl_addr_00", 32'(ADDR), 32'h00);
        SO = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK); SO = pay[i];
        end
        @(negedge CLK);
        check("unl_busy_end", 32'(BUSY), 32'd1);
        check("unl_unlocked_early", 32'(UNLOCKED), 32'd0);
        SO = stop_b;
        @(negedge CLK); SO = 1'b1;
        check("unl_unlocked", 32'(UNLOCKED), 32'(exp_ok));
        check("unl_fail", 32'(FAIL), 32'(!exp_ok));
        check("unl_busy_done", 32'(BUSY), 32'd0);
        check("unl_word", 32'(WORD), 32'(pay));
    endtask

    task automatic do_access(input logic we, input logic [1:0] idx, input logic [7:0] wdata,
                             input logic extra);
        logic [7:0] exp_addr;
        logic [7:0] exp_rd;
        logic       seen;
        exp_addr = {6'b110000, idx};
        exp_rd   = cart_reg[idx];
        @(negedge CLK);
        REQ = 1'b1; REQ_WE = we; REQ_IDX = idx; REQ_WDATA = wdata;
        @(negedge CLK); REQ = 1'b0;
        check("acc_setup_addr", 32'(ADDR), 32'(exp_addr));
        check("acc_setup_cen", 32'(CEn), 32'd0);
        check("acc_setup_strb", 32'({OEn, WEn}), 32'b11);
        check("acc_setup_dq_oe", 32'(DQ_OE), 32'(we));
        if (we) check("acc_setup_dq_out", 32'(DQ_OUT), 32'(wdata));
        @(negedge CLK);
        check("acc_strobe1", 32'({OEn, WEn}), we ? 32'b10 : 32'b01);
        check("acc_strobe1_addr", 32'(ADDR), 32'(exp_addr));
        check("acc_strobe1_dq_oe", 32'(DQ_OE), 32'(we));
        if (!we) DQ_IN = exp_rd;
        if (extra) REQ = 1'b1;
        @(negedge CLK); REQ = 1'b0;
        check("acc_strobe2", 32'({OEn, WEn}), we ? 32'b10 : 32'b01);
        @(negedge CLK); DQ_IN = 8'h00;
        check("acc_hold_strb", 32'({OEn, WEn}), 32'b11);
        check("acc_hold_cen", 32'(CEn), 32'd0);
        check("acc_hold_addr", 32'(ADDR), 32'(exp_addr));
        check("acc_hold_dq_oe", 32'(DQ_OE), 32'(we));
        check("acc_hold_ack", 32'(ACK), 32'd0);
        @(negedge CLK);
        check("acc_ack", 32'(ACK), 32'd1);
        check("acc_idle_cen", 32'(CEn), 32'd1);
        check("acc_idle_dq_oe", 32'(DQ_OE), 32'd0);
        check("acc_idle_addr", 32'(ADDR), 32'h00);
        if (!we) check("acc_rdata", 32'(RDATA), 32'(exp_rd));
        else     cart_reg[idx] = wdata;
        if (extra) REQ = 1'b1;
        @(negedge CLK); REQ = 1'b0;
        check("acc_ack_pulse", 32'(ACK), 32'd0);
        if (extra) begin
            seen = 1'b0;
            repeat (6) begin
                @(negedge CLK);
                seen = seen | ACK | !CEn;
            end
            check("acc_dropped_req", 32'(seen), 32'd0);
        end
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 4; i++) cart_reg[i] = 8'h00;
        repeat (2) @(negedge CLK);
        check_reset_outputs("por");
        RST = 1'b0;

        // request before unlock: no bus activity, no ACK
        @(negedge CLK); REQ = 1'b1; REQ_WE = 1'b1; REQ_IDX = 2'd1; REQ_WDATA = 8'h11;
        @(negedge CLK); REQ = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            seen = seen | ACK | !CEn | BUSY;
        end
        check("req_locked", 32'(seen), 32'd0);

        do_unlock(16'h28A1, 1'b0, 1'b0);
        do_unlock(16'h28A0, 1'b0, 1'b1);

        // START in READY is ignored
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            seen = seen | (ADDR != 8'h00) | BUSY | !UNLOCKED;
            @(negedge CLK);
        end
        check("start_in_ready", 32'(seen), 32'd0);

        do_access(1'b1, 2'd2, 8'h5A, 1'b0);
        do_access(1'b0, 2'd2, 8'h00, 1'b0);
        do_access(1'b1, 2'd0, 8'hA3, 1'b1);
        do_access(1'b0, 2'd0, 8'h00, 1'b0);
        check("rdata_held", 32'(RDATA), 32'hA3);

        // reset in the middle of a read strobe
        @(negedge CLK); REQ = 1'b1; REQ_WE = 1'b0; REQ_IDX = 2'd3;
        @(negedge CLK); REQ = 1'b0;
        @(negedge CLK);
        check("rst_strobe_pre", 32'(OEn), 32'd0);
        apply_rst("rst_strobe");

        // no start bit: timeout
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        repeat (2) @(negedge CLK);
        repeat (BIT_TO) @(negedge CLK);
        check("to_fail_early", 32'(FAIL), 32'd0);
        check("to_busy_early", 32'(BUSY), 32'd1);
        @(negedge CLK);
        check("to_fail", 32'(FAIL), 32'd1);
        check("to_busy", 32'(BUSY), 32'd0);
        check("to_unlocked", 32'(UNLOCKED), 32'd0);

        // good payload but stop bit high
        do_unlock(16'h28A0, 1'b1, 1'b0);

        // reset while shifting payload
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        repeat (2) @(negedge CLK);
        SO = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); SO = i[0];
        end
        check("rst_shift_pre", 32'(BUSY), 32'd1);
        apply_rst("rst_shift");

        do_unlock(16'h28A0, 1'b0, 1'b1);
        do_access(1'b1, 2'd3, 8'hC7, 1'b0);
        do_access(1'b0, 2'd3, 8'h00, 1'b0);
        check("final_rdata", 32'(RDATA), 32'hC7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
